// File: rtl/lut3_eval_unit_pkg.sv
// Shared constants and sweep FSM encoding for the 3-input LUT evaluator.
package lut3_eval_unit_pkg;

  // Truth table of the classic s = a & ~(b & c); bit index = {a,b,c}.
  localparam logic [7:0] DEFAULT_MASK = 8'h70;

  localparam int SWEEP_LEN = 8;
  localparam logic [2:0] SWEEP_LAST = 3'(SWEEP_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/lut3_lane.sv
// One-bit 3-input lookup: returns mask[{a,b,c}].
module lut3_lane (
  input  logic [7:0] mask_i,
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  output logic       s_o
);

  logic [2:0] sel;

  assign sel = {a_i, b_i, c_i};
  assign s_o = mask_i[sel];

endmodule

// File: rtl/lut3_eval_unit.sv
// Streaming programmable 3-input function over WIDTH lanes, with a registered
// output stage and a sweep mode that replays all 8 input codes through a lane.
//
// Handshake: a beat transfers on a rising edge where valid & ready are both 1.
// in_ready = IDLE & (~out_valid | out_ready), independent of in_valid; the
// result appears one cycle after the accept and holds while out_ready is low.
module lut3_eval_unit
  import lut3_eval_unit_pkg::*;
#(
  parameter int         WIDTH        = 4,
  parameter logic [7:0] DEFAULT_MASK = lut3_eval_unit_pkg::DEFAULT_MASK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mask_load,
  input  logic [7:0]       mask_in,
  output logic [7:0]       mask,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [7:0]       sweep_table,
  output logic [1:0]       fsm_state
);

  sweep_state_e     state_q;
  logic [2:0]       idx_q;
  logic [7:0]       mask_q;
  logic [7:0]       table_q;
  logic [WIDTH-1:0] s_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] lane_s;
  logic             sweep_bit;
  logic             accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    lut3_lane u_lane (
      .mask_i (mask_q),
      .a_i    (a[i]),
      .b_i    (b[i]),
      .c_i    (c[i]),
      .s_o    (lane_s[i])
    );
  end

  // Sweep drives the sweep index in as {a,b,c}, exercising the same lookup.
  lut3_lane u_sweep_lane (
    .mask_i (mask_q),
    .a_i    (idx_q[2]),
    .b_i    (idx_q[1]),
    .c_i    (idx_q[0]),
    .s_o    (sweep_bit)
  );

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q      <= DEFAULT_MASK;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      table_q     <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (mask_load && !busy_q) mask_q <= mask_in;

      if (accept) begin
        out_valid_q <= 1'b1;
        s_q         <= lane_s;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sweep_start && !out_valid_q) begin
            state_q <= ST_RUN;
            idx_q   <= 3'd0;
            table_q <= 8'h00;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          table_q[idx_q] <= sweep_bit;
          idx_q          <= idx_q + 3'd1;
          if (idx_q == SWEEP_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mask        = mask_q;
  assign out_valid   = out_valid_q;
  assign s           = s_q;
  assign sweep_busy  = busy_q;
  assign sweep_done  = done_q;
  assign sweep_table = table_q;
  assign fsm_state   = state_q;

endmodule
